pc_run_controller: RTL and testbench
====================================

# pc_run_controller

Run/step/halt sequencer for the program counter of the single-cycle core. Decides each cycle whether the PC may load its next address, from operator controls (run, stop, single-step button), the decoded halt instruction, and an optional address breakpoint. Drives the PC's `enable` and `halt` inputs so that neither sequential fetch nor taken branches advance the PC unless this block permits it. Also keeps a saturating count of executed instructions for the board display.

## Interface
Parameters:
- `CNT_W`, 16: width of the executed-instruction counter.
- `ADDR_W`, 5: instruction address width; must match the PC.

Ports:
- `clk`  in  1  system clock; all state on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `run_req`  in  1  level; requests free-running execution from IDLE.
- `stop_req`  in  1  level; stops free-running execution.
- `step_btn`  in  1  raw, asynchronous push-button; each rising edge requests one instruction.
- `halt_inst`  in  1  combinational decode: the instruction at `curr_inst_addr` is HALT.
- `curr_inst_addr`  in  ADDR_W  current PC value.
- `bp_addr`  in  ADDR_W  breakpoint address (macro only).
- `bp_valid`  in  1  breakpoint enabled (macro only).
- `pc_enable`  out  1  to PC `enable`; the PC advances this cycle.
- `pc_halt`  out  1  to PC `halt`; always `~pc_enable`.
- `state`  out  2  IDLE=00, RUN=01, STEP=10, HALTED=11.
- `inst_count`  out  CNT_W  number of cycles with `pc_enable`=1, saturating.

## Operation
- Step synchronizer: `step_btn` passes through two flops, then a third "previous" flop; `step_pulse` = sync2 & ~prev. This produces exactly one cycle per button press.
- `advance` (combinational, Mealy):
  - RUN: `advance` = `!halt_inst && !stop_req && !bp_hit`.
  - STEP: `advance` = `!halt_inst`.
  - IDLE and HALTED: `advance` = 0.
- `pc_enable` = `advance`; `pc_halt` = `!advance`.
- State transitions:
  - IDLE: `step_pulse` → STEP; else `run_req` → RUN. Step has priority over run.
  - RUN: `halt_inst` → HALTED; else `stop_req` → IDLE; else `bp_hit` → IDLE; else stay in RUN. Priority is halt > stop > breakpoint.
  - STEP: `halt_inst` → HALTED; else → IDLE after exactly one advance.
  - HALTED: absorbing. Only `reset_n` exits. `run_req`, `stop_req` and `step_pulse` are ignored.
- `step_pulse` is ignored outside IDLE and is not queued.
- `inst_count` increments on every edge where `advance`=1. It holds at all-ones when saturated.

## Timing
- Reset (async assert, synchronous deassert handled externally): `state`=IDLE, `pc_enable`=0, `pc_halt`=1, `inst_count`=0, synchronizer flops=0, `bp_armed`=1.
- Run latency: `run_req` high before edge k → RUN after edge k. `pc_enable`=1 in the cycle after edge k, and the PC first moves at edge k+1.
- Stop latency: `stop_req` suppresses `pc_enable` in the same cycle (combinational). IDLE is entered at the next edge.
- Step latency: `step_btn` rises before edge k. `step_pulse`=1 in the cycle after edge k+1. STEP is entered at edge k+2. The PC advances exactly once, at edge k+3. IDLE is entered at edge k+3.
- HALT: the PC never loads past the HALT address. `pc_enable` drops in the same cycle `halt_inst` rises.
- `inst_count` updates on the same edge as the PC.

## Configuration
- Macro `PC_RUN_CTRL_BREAKPOINT_EN`.
- Defined:
  - `bp_hit` = `bp_valid && bp_armed && (curr_inst_addr == bp_addr)`.
  - `bp_armed` clears on the edge leaving RUN due to `bp_hit`. It sets on any edge with `advance`=1.
  - Effect: resuming RUN or STEP from the breakpoint address executes that instruction before the breakpoint can fire again.
- Undefined:
  - `bp_addr`, `bp_valid` and `bp_armed` are absent; `bp_hit`=0.
  - RUN leaves only on halt or stop.

## Test plan
- Reset mid-RUN: assert `reset_n`=0 at PC=7 → `state`=00, `pc_enable`=0, `pc_halt`=1, `inst_count`=0 asynchronously.
- Run/stop: `run_req`=1 for 1 cycle from IDLE at PC=0, then `stop_req`=1 after 5 `pc_enable` cycles → `pc_enable`=0 in the `stop_req` cycle, `inst_count`=5, `state`=IDLE.
- Single step: 20-cycle `step_btn` pulse in IDLE → `pc_enable` high exactly one cycle, three edges after the button rise; `inst_count`=1; a held button gives no second step.
- HALT in RUN: `halt_inst`=1 at PC=9 → PC stays 9, `state`=HALTED. Further `run_req`/`step_btn` → no `pc_enable`.
- Breakpoint (macro on): `bp_addr`=4, `bp_valid`=1, run from 0 → IDLE with PC=4, `inst_count`=4. `run_req` again → PC advances past 4 with no re-hit.
- Simultaneous events: `step_pulse` and `run_req` in the same IDLE cycle → STEP, one advance, then IDLE. In RUN, `halt_inst` and `stop_req` together → HALTED.

Source files
------------

// File: rtl/pc_run_controller.sv
// -----------------------------------------------------------------------------
// pc_run_controller
//
// Run/step/halt sequencer for the single-cycle core's program counter. Each
// cycle it decides whether the PC may load its next address, based on the
// operator controls (run, stop, single-step button), the decoded HALT
// instruction and, optionally, an address breakpoint. It also keeps a
// saturating count of executed instructions for the board display.
//
// Optional feature macro: PC_RUN_CTRL_BREAKPOINT_EN
//   Defined   -> bp_addr / bp_valid ports exist and RUN stops (to IDLE) when
//                the PC reaches an armed breakpoint address.
//   Undefined -> no breakpoint ports; RUN leaves only on halt or stop.
//
// Parameters:
//   CNT_W   width of the executed-instruction counter
//   ADDR_W  instruction address width (must match the PC)
//
// Ports:
//   clk             system clock, rising edge
//   reset_n         asynchronous active-low reset
//   run_req         level, start free-running execution from IDLE
//   stop_req        level, stop free-running execution
//   step_btn        raw asynchronous push-button, one instruction per press
//   halt_inst       decode: instruction at curr_inst_addr is HALT
//   curr_inst_addr  current PC value
//   bp_addr         breakpoint address            (macro only)
//   bp_valid        breakpoint enable             (macro only)
//   pc_enable       PC advances this cycle (combinational)
//   pc_halt         always ~pc_enable
//   state           IDLE=00, RUN=01, STEP=10, HALTED=11
//   inst_count      saturating count of cycles with pc_enable=1
// -----------------------------------------------------------------------------
module pc_run_controller #(
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              run_req,
    input  logic              stop_req,
    input  logic              step_btn,
    input  logic              halt_inst,
    input  logic [ADDR_W-1:0] curr_inst_addr,
`ifdef PC_RUN_CTRL_BREAKPOINT_EN
    input  logic [ADDR_W-1:0] bp_addr,
    input  logic              bp_valid,
`endif
    output logic              pc_enable,
    output logic              pc_halt,
    output logic [1:0]        state,
    output logic [CNT_W-1:0]  inst_count
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_RUN    = 2'b01,
        S_STEP   = 2'b10,
        S_HALTED = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t cur_state;
    state_t nxt_state;
    logic   advance;
    logic   bp_hit;

    // Step button synchronizer and rising-edge detector.
    logic step_sync1;
    logic step_sync2;
    logic step_prev;
    logic step_pulse;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            step_sync1 <= 1'b0;
            step_sync2 <= 1'b0;
            step_prev  <= 1'b0;
        end else begin
            step_sync1 <= step_btn;
            step_sync2 <= step_sync1;
            step_prev  <= step_sync2;
        end
    end

    assign step_pulse = step_sync2 & ~step_prev;

`ifdef PC_RUN_CTRL_BREAKPOINT_EN
    // Breakpoint is disarmed after it stops RUN so that resuming executes the
    // instruction at the breakpoint address before it can fire again.
    logic bp_armed;
    logic bp_leave;

    assign bp_hit   = bp_valid && bp_armed && (curr_inst_addr == bp_addr);
    assign bp_leave = (cur_state == S_RUN) && !halt_inst && !stop_req && bp_hit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bp_armed <= 1'b1;
        end else if (advance) begin
            bp_armed <= 1'b1;
        end else if (bp_leave) begin
            bp_armed <= 1'b0;
        end
    end
`else
    logic unused_addr;

    assign bp_hit      = 1'b0;
    assign unused_addr = ^curr_inst_addr;
`endif

    // Next-state and advance decision (advance is Mealy so stop/halt act
    // within the same cycle).
    always_comb begin
        nxt_state = cur_state;
        advance   = 1'b0;
        unique case (cur_state)
            S_IDLE: begin
                if (step_pulse) begin
                    nxt_state = S_STEP;
                end else if (run_req) begin
                    nxt_state = S_RUN;
                end
            end
            S_RUN: begin
                advance = !halt_inst && !stop_req && !bp_hit;
                if (halt_inst) begin
                    nxt_state = S_HALTED;
                end else if (stop_req || bp_hit) begin
                    nxt_state = S_IDLE;
                end
            end
            S_STEP: begin
                advance = !halt_inst;
                if (halt_inst) begin
                    nxt_state = S_HALTED;
                end else begin
                    nxt_state = S_IDLE;
                end
            end
            S_HALTED: begin
                nxt_state = S_HALTED;
            end
            default: begin
                nxt_state = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_state <= S_IDLE;
        end else begin
            cur_state <= nxt_state;
        end
    end

    // Saturating executed-instruction counter, updated with the PC.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inst_count <= '0;
        end else if (advance && (inst_count != CNT_MAX)) begin
            inst_count <= inst_count + CNT_W'(1);
        end
    end

    assign pc_enable = advance;
    assign pc_halt   = ~advance;
    assign state     = 2'(cur_state);

endmodule

// File: tb/tb_pc_run_controller.sv
// -----------------------------------------------------------------------------
// tb_pc_run_controller
//
// Directed self-checking bench for pc_run_controller. A small PC model in the
// bench advances on pc_enable and drives curr_inst_addr; halt_inst decodes a
// programmable HALT address. The counter is instantiated 4 bits wide so that
// saturation is reachable in a short run.
// -----------------------------------------------------------------------------
module tb_pc_run_controller;

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned ADDR_W = 5;

    logic              clk;
    logic              reset_n;
    logic              run_req;
    logic              stop_req;
    logic              step_btn;
    logic              halt_inst;
    logic [ADDR_W-1:0] pc;
    logic              pc_enable;
    logic              pc_halt;
    logic [1:0]        state;
    logic [CNT_W-1:0]  inst_count;
`ifdef PC_RUN_CTRL_BREAKPOINT_EN
    logic [ADDR_W-1:0] bp_addr;
    logic              bp_valid;
`endif

    logic              halt_en;
    logic [ADDR_W-1:0] halt_addr;

    int checks;
    int failures;

    pc_run_controller #(
        .CNT_W (CNT_W),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .run_req       (run_req),
        .stop_req      (stop_req),
        .step_btn      (step_btn),
        .halt_inst     (halt_inst),
        .curr_inst_addr(pc),
`ifdef PC_RUN_CTRL_BREAKPOINT_EN
        .bp_addr       (bp_addr),
        .bp_valid      (bp_valid),
`endif
        .pc_enable     (pc_enable),
        .pc_halt       (pc_halt),
        .state         (state),
        .inst_count    (inst_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program counter model: sequential fetch gated by pc_enable.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) pc <= '0;
        else if (pc_enable) pc <= pc + 5'd1;
    end

    assign halt_inst = halt_en && (pc == halt_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_reset();
        #1 reset_n = 1'b0;
        #1 reset_n = 1'b1;
        cyc(1);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset_n   = 1'b0;
        run_req   = 1'b0;
        stop_req  = 1'b0;
        step_btn  = 1'b0;
        halt_en   = 1'b0;
        halt_addr = '0;
`ifdef PC_RUN_CTRL_BREAKPOINT_EN
        bp_addr   = '0;
        bp_valid  = 1'b0;
`endif

        // Reset state.
        #2;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_pc_enable", 32'(pc_enable), 32'd0);
        chk("rst_pc_halt", 32'(pc_halt), 32'd1);
        chk("rst_count", 32'(inst_count), 32'd0);
        @(posedge clk);
        #3 reset_n = 1'b1;
        cyc(1);

        // Run for five instructions, then stop.
        run_req = 1'b1;
        cyc(1);
        run_req = 1'b0;
        chk("run_state", 32'(state), 32'd1);
        chk("run_first_enable", 32'(pc_enable), 32'd1);
        chk("run_first_pc", 32'(pc), 32'd0);
        cyc(5);
        chk("run_pc5", 32'(pc), 32'd5);
        stop_req = 1'b1;
        #1;
        chk("stop_same_cycle_enable", 32'(pc_enable), 32'd0);
        chk("stop_same_cycle_halt", 32'(pc_halt), 32'd1);
        cyc(1);
        stop_req = 1'b0;
        chk("stop_state", 32'(state), 32'd0);
        chk("stop_count", 32'(inst_count), 32'd5);
        chk("stop_pc", 32'(pc), 32'd5);

        // Single step with a 20-cycle button press.
        step_btn = 1'b1;
        cyc(1);
        chk("step_k_enable", 32'(pc_enable), 32'd0);
        cyc(1);
        chk("step_k1_enable", 32'(pc_enable), 32'd0);
        chk("step_k1_state", 32'(state), 32'd0);
        cyc(1);
        chk("step_k2_state", 32'(state), 32'd2);
        chk("step_k2_enable", 32'(pc_enable), 32'd1);
        cyc(1);
        chk("step_k3_state", 32'(state), 32'd0);
        chk("step_k3_enable", 32'(pc_enable), 32'd0);
        chk("step_count", 32'(inst_count), 32'd6);
        cyc(16);
        chk("step_held_pc", 32'(pc), 32'd6);
        chk("step_held_count", 32'(inst_count), 32'd6);
        step_btn = 1'b0;
        cyc(3);

        // Step pulse and run request in the same IDLE cycle: step wins.
        step_btn = 1'b1;
        cyc(2);
        run_req = 1'b1;
        cyc(1);
        chk("simul_step_state", 32'(state), 32'd2);
        run_req = 1'b0;
        cyc(1);
        chk("simul_idle_state", 32'(state), 32'd0);
        chk("simul_pc", 32'(pc), 32'd7);
        chk("simul_count", 32'(inst_count), 32'd7);
        step_btn = 1'b0;
        cyc(3);

        // Asynchronous reset in the middle of RUN at PC=7.
        run_req = 1'b1;
        cyc(1);
        run_req = 1'b0;
        chk("midrun_state", 32'(state), 32'd1);
        chk("midrun_pc", 32'(pc), 32'd7);
        #1 reset_n = 1'b0;
        #1;
        chk("async_rst_state", 32'(state), 32'd0);
        chk("async_rst_enable", 32'(pc_enable), 32'd0);
        chk("async_rst_halt", 32'(pc_halt), 32'd1);
        chk("async_rst_count", 32'(inst_count), 32'd0);
        #1 reset_n = 1'b1;
        cyc(1);

        // HALT at PC=9 during RUN.
        halt_addr = 5'd9;
        halt_en   = 1'b1;
        run_req   = 1'b1;
        cyc(1);
        run_req   = 1'b0;
        cyc(9);
        chk("halt_pc", 32'(pc), 32'd9);
        chk("halt_same_cycle_enable", 32'(pc_enable), 32'd0);
        chk("halt_count", 32'(inst_count), 32'd9);
        cyc(1);
        chk("halted_state", 32'(state), 32'd3);
        run_req  = 1'b1;
        step_btn = 1'b1;
        cyc(5);
        chk("halted_absorb_state", 32'(state), 32'd3);
        chk("halted_absorb_enable", 32'(pc_enable), 32'd0);
        chk("halted_absorb_pc", 32'(pc), 32'd9);
        run_req  = 1'b0;
        step_btn = 1'b0;
        halt_en  = 1'b0;
        pulse_reset();

        // Halt and stop together in RUN: halt wins.
        run_req = 1'b1;
        cyc(1);
        run_req = 1'b0;
        cyc(2);
        halt_addr = 5'd2;
        halt_en   = 1'b1;
        stop_req  = 1'b1;
        #1;
        chk("halt_stop_enable", 32'(pc_enable), 32'd0);
        cyc(1);
        chk("halt_stop_state", 32'(state), 32'd3);
        chk("halt_stop_pc", 32'(pc), 32'd2);
        stop_req = 1'b0;
        halt_en  = 1'b0;
        pulse_reset();

`ifdef PC_RUN_CTRL_BREAKPOINT_EN
        // Breakpoint at address 4, then resume past it.
        bp_addr  = 5'd4;
        bp_valid = 1'b1;
        run_req  = 1'b1;
        cyc(1);
        run_req  = 1'b0;
        cyc(4);
        chk("bp_pc", 32'(pc), 32'd4);
        chk("bp_same_cycle_enable", 32'(pc_enable), 32'd0);
        cyc(1);
        chk("bp_state", 32'(state), 32'd0);
        chk("bp_count", 32'(inst_count), 32'd4);
        run_req = 1'b1;
        cyc(1);
        run_req = 1'b0;
        chk("bp_resume_enable", 32'(pc_enable), 32'd1);
        cyc(1);
        chk("bp_resume_pc", 32'(pc), 32'd5);
        chk("bp_resume_state", 32'(state), 32'd1);
        stop_req = 1'b1;
        cyc(1);
        stop_req = 1'b0;
        bp_valid = 1'b0;
        pulse_reset();
`endif

        // Counter saturation (4-bit counter holds at 15).
        run_req = 1'b1;
        cyc(1);
        run_req = 1'b0;
        cyc(20);
        chk("sat_pc", 32'(pc), 32'd20);
        chk("sat_count", 32'(inst_count), 32'd15);
        chk("sat_state", 32'(state), 32'd1);
        stop_req = 1'b1;
        cyc(1);
        stop_req = 1'b0;
        chk("sat_stop_state", 32'(state), 32'd0);
        chk("sat_stop_count", 32'(inst_count), 32'd15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
